multi_stage_sync_filter: RTL and testbench

//   Parametrised successor to the two-flip-flop synchroniser. Brings WIDTH independent

---
 rtl/multi_stage_sync_filter.sv | 79 +++++++
 tb/tb_multi_stage_sync_filter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multi_stage_sync_filter.sv
// Multi-channel synchroniser with per-channel stability filter and registered edge pulses.
// Build option: define SYNC_EDGE_PULSE_EN to build rise/fall pulse registers (otherwise tied to 0).
`timescale 1ns/1ps
module multi_stage_sync_filter #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [WIDTH-1:0] chain_p [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] accept;

    // Synchroniser chain: plain shift, no logic between stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < STAGES; j++) chain_p[j] <= RESET_VAL;
        end else begin
            chain_p[0] <= async_in;
            for (int j = 1; j < STAGES; j++) chain_p[j] <= chain_p[j-1];
        end
    end

    assign s = chain_p[STAGES-1];

    // Filter stage: a new level is taken only after FILTER_LEN consecutive differing samples
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CW-1:0] cnt;

        assign accept[i] = (s[i] != sync_out[i]) && (cnt == CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (s[i] == sync_out[i] || accept[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // accept implies s differs from sync_out, so toggling loads the new level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_out <= RESET_VAL;
        end else begin
            sync_out <= sync_out ^ accept;
        end
    end

`ifdef SYNC_EDGE_PULSE_EN
    // Pulse stage: aligned with the cycle the new sync_out value first shows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= accept & ~sync_out;
            fall_pulse <= accept & sync_out;
        end
    end
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_multi_stage_sync_filter.sv
// Directed bench for multi_stage_sync_filter: FILTER_LEN=4 and FILTER_LEN=1 instances share stimulus.
`timescale 1ns/1ps
module tb_multi_stage_sync_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] async_in = 4'b0000;
    logic [3:0] out4, rp4, fp4, out1, rp1, fp1;
    int         checks = 0;
    int         errors = 0;

`ifdef SYNC_EDGE_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    always #5 clk = ~clk;

    multi_stage_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'b0000)) u_f4 (
        .clk(clk), .rst(rst), .async_in(async_in),
        .sync_out(out4), .rise_pulse(rp4), .fall_pulse(fp4)
    );

    multi_stage_sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_LEN(1), .RESET_VAL(4'b0000)) u_f1 (
        .clk(clk), .rst(rst), .async_in(async_in),
        .sync_out(out1), .rise_pulse(rp1), .fall_pulse(fp1)
    );

    task automatic at(input longint t);
        if (t > $time) #(t - $time);
    endtask

    task automatic test_reset;
        at(1);
        checks++; if (out4 !== 4'b0000) begin errors++; $display("FAIL reset_out4 @%0t got %b expected 0000", $time, out4); end
        checks++; if (rp4 !== 4'b0000) begin errors++; $display("FAIL reset_rp4 @%0t got %b expected 0000", $time, rp4); end
        checks++; if (fp4 !== 4'b0000) begin errors++; $display("FAIL reset_fp4 @%0t got %b expected 0000", $time, fp4); end
        checks++; if (out1 !== 4'b0000) begin errors++; $display("FAIL reset_out1 @%0t got %b expected 0000", $time, out1); end
        at(2);
        rst = 1'b0;
    endtask

    task automatic test_glitch;
        logic [3:0] e1, er1, ef1;
        at(7); async_in = 4'b0001;
        for (int t = 10; t <= 100; t += 10) begin
            at(t);
            e1  = (t == 40) ? 4'b0001 : 4'b0000;
            er1 = (PE && t == 40) ? 4'b0001 : 4'b0000;
            ef1 = (PE && t == 50) ? 4'b0001 : 4'b0000;
            checks++; if (out4 !== 4'b0000) begin errors++; $display("FAIL glitch_out4 @%0t got %b expected 0000", $time, out4); end
            checks++; if (rp4 !== 4'b0000) begin errors++; $display("FAIL glitch_rp4 @%0t got %b expected 0000", $time, rp4); end
            checks++; if (out1 !== e1) begin errors++; $display("FAIL glitch_out1 @%0t got %b expected %b", $time, out1, e1); end
            checks++; if (rp1 !== er1) begin errors++; $display("FAIL glitch_rp1 @%0t got %b expected %b", $time, rp1, er1); end
            checks++; if (fp1 !== ef1) begin errors++; $display("FAIL glitch_fp1 @%0t got %b expected %b", $time, fp1, ef1); end
            if (t == 10) begin at(17); async_in = 4'b0000; end
        end
    endtask

    task automatic test_hold;
        logic [3:0] e4, er4, e1, er1;
        at(107); async_in = 4'b0001;
        for (int t = 110; t <= 200; t += 10) begin
            at(t);
            e4  = (t >= 170) ? 4'b0001 : 4'b0000;
            er4 = (PE && t == 170) ? 4'b0001 : 4'b0000;
            e1  = (t >= 140) ? 4'b0001 : 4'b0000;
            er1 = (PE && t == 140) ? 4'b0001 : 4'b0000;
            checks++; if (out4 !== e4) begin errors++; $display("FAIL hold_out4 @%0t got %b expected %b", $time, out4, e4); end
            checks++; if (rp4 !== er4) begin errors++; $display("FAIL hold_rp4 @%0t got %b expected %b", $time, rp4, er4); end
            checks++; if (fp4 !== 4'b0000) begin errors++; $display("FAIL hold_fp4 @%0t got %b expected 0000", $time, fp4); end
            checks++; if (out1 !== e1) begin errors++; $display("FAIL hold_out1 @%0t got %b expected %b", $time, out1, e1); end
            checks++; if (rp1 !== er1) begin errors++; $display("FAIL hold_rp1 @%0t got %b expected %b", $time, rp1, er1); end
        end
    endtask

    task automatic test_short_drop;
        logic [3:0] e1, er1, ef1;
        at(207); async_in = 4'b0000;
        for (int t = 210; t <= 300; t += 10) begin
            at(t);
            e1  = (t == 240 || t == 250) ? 4'b0000 : 4'b0001;
            ef1 = (PE && t == 240) ? 4'b0001 : 4'b0000;
            er1 = (PE && t == 260) ? 4'b0001 : 4'b0000;
            checks++; if (out4 !== 4'b0001) begin errors++; $display("FAIL drop_out4 @%0t got %b expected 0001", $time, out4); end
            checks++; if (fp4 !== 4'b0000) begin errors++; $display("FAIL drop_fp4 @%0t got %b expected 0000", $time, fp4); end
            checks++; if (out1 !== e1) begin errors++; $display("FAIL drop_out1 @%0t got %b expected %b", $time, out1, e1); end
            checks++; if (fp1 !== ef1) begin errors++; $display("FAIL drop_fp1 @%0t got %b expected %b", $time, fp1, ef1); end
            checks++; if (rp1 !== er1) begin errors++; $display("FAIL drop_rp1 @%0t got %b expected %b", $time, rp1, er1); end
            if (t == 220) begin at(227); async_in = 4'b0001; end
        end
    endtask

    task automatic test_fall;
        logic [3:0] e4, ef4, e1, ef1;
        at(307); async_in = 4'b0000;
        for (int t = 310; t <= 400; t += 10) begin
            at(t);
            e4  = (t >= 370) ? 4'b0000 : 4'b0001;
            ef4 = (PE && t == 370) ? 4'b0001 : 4'b0000;
            e1  = (t >= 340) ? 4'b0000 : 4'b0001;
            ef1 = (PE && t == 340) ? 4'b0001 : 4'b0000;
            checks++; if (out4 !== e4) begin errors++; $display("FAIL fall_out4 @%0t got %b expected %b", $time, out4, e4); end
            checks++; if (fp4 !== ef4) begin errors++; $display("FAIL fall_fp4 @%0t got %b expected %b", $time, fp4, ef4); end
            checks++; if (rp4 !== 4'b0000) begin errors++; $display("FAIL fall_rp4 @%0t got %b expected 0000", $time, rp4); end
            checks++; if (out1 !== e1) begin errors++; $display("FAIL fall_out1 @%0t got %b expected %b", $time, out1, e1); end
            checks++; if (fp1 !== ef1) begin errors++; $display("FAIL fall_fp1 @%0t got %b expected %b", $time, fp1, ef1); end
        end
    endtask

    task automatic test_multi_channel;
        logic [3:0] e4, er4, ef4;
        at(407); async_in = 4'b1010;
        for (int t = 410; t <= 600; t += 10) begin
            at(t);
            e4  = (t >= 470 && t < 570) ? 4'b1010 : 4'b0000;
            er4 = (PE && t == 470) ? 4'b1010 : 4'b0000;
            ef4 = (PE && t == 570) ? 4'b1010 : 4'b0000;
            checks++; if (out4 !== e4) begin errors++; $display("FAIL multi_out4 @%0t got %b expected %b", $time, out4, e4); end
            checks++; if (rp4 !== er4) begin errors++; $display("FAIL multi_rp4 @%0t got %b expected %b", $time, rp4, er4); end
            checks++; if (fp4 !== ef4) begin errors++; $display("FAIL multi_fp4 @%0t got %b expected %b", $time, fp4, ef4); end
            if (t == 500) begin at(507); async_in = 4'b0000; end
        end
    endtask

    task automatic test_reset_mid_filter;
        logic [3:0] e4, er4, e1, er1;
        at(607); async_in = 4'b1111;
        for (int t = 610; t <= 720; t += 10) begin
            at(t);
            e4  = (t >= 700) ? 4'b1111 : 4'b0000;
            er4 = (PE && t == 700) ? 4'b1111 : 4'b0000;
            e1  = (t >= 670) ? 4'b1111 : 4'b0000;
            er1 = (PE && t == 670) ? 4'b1111 : 4'b0000;
            checks++; if (out4 !== e4) begin errors++; $display("FAIL rstmid_out4 @%0t got %b expected %b", $time, out4, e4); end
            checks++; if (rp4 !== er4) begin errors++; $display("FAIL rstmid_rp4 @%0t got %b expected %b", $time, rp4, er4); end
            checks++; if (fp4 !== 4'b0000) begin errors++; $display("FAIL rstmid_fp4 @%0t got %b expected 0000", $time, fp4); end
            checks++; if (out1 !== e1) begin errors++; $display("FAIL rstmid_out1 @%0t got %b expected %b", $time, out1, e1); end
            checks++; if (rp1 !== er1) begin errors++; $display("FAIL rstmid_rp1 @%0t got %b expected %b", $time, rp1, er1); end
            if (t == 630) begin
                at(633); rst = 1'b1;
                at(635);
                checks++; if (out4 !== 4'b0000) begin errors++; $display("FAIL inrst_out4 @%0t got %b expected 0000", $time, out4); end
                checks++; if (out1 !== 4'b0000) begin errors++; $display("FAIL inrst_out1 @%0t got %b expected 0000", $time, out1); end
                checks++; if ((rp1 | fp1) !== 4'b0000) begin errors++; $display("FAIL inrst_pulse1 @%0t got %b expected 0000", $time, rp1 | fp1); end
                at(637); rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_hold;
        test_short_drop;
        test_fall;
        test_multi_channel;
        test_reset_mid_filter;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
